// File: rtl/adrv9001_capture_pkg.sv
// Shared definitions for the adrv9001 AXIS capture block.
// Holds the FSM state encodings (also visible on the top-level state port)
// and the trig_mode selector values.
package adrv9001_capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PREFILL   = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_POST      = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  localparam logic [1:0] TRIG_IMMEDIATE = 2'd0;
  localparam logic [1:0] TRIG_TLAST     = 2'd1;
  localparam logic [1:0] TRIG_EXT       = 2'd2;
  localparam logic [1:0] TRIG_PERIODIC  = 2'd3;

endpackage

// File: rtl/adrv9001_capture_ram.sv
// Simple dual-port capture buffer: one write port, one registered read port.
// Ports:
//   clk          clock for both ports
//   we/waddr/wdata  write strobe, address, data
//   re/raddr     read strobe and address
//   rdata        read data, valid the cycle after re
// No reset on the array or read register, so it maps onto block RAM.
module adrv9001_capture_ram #(
  parameter int WIDTH      = 48,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/adrv9001_axis_capture.sv
// AXI-Stream capture tap: records {tdata, aux} per beat into a circular
// buffer with programmable pre-trigger depth and four trigger modes, and
// reads the capture back in logical order (index 0 = oldest beat).
// Ports:
//   clk, rst                      clock, async active-high reset
//   s_axis_*                      monitored stream (beat = tvalid & tready)
//   aux                           side word stored with each beat
//   arm, abort                    start / cancel a capture (abort wins)
//   trig_mode, trig_ext, period_cnt  trigger selection and sources
//   pretrig_cnt                   beats kept before the trigger, sampled on arm
//   rd_addr, rd_en                logical read index and strobe
//   rd_data, rd_aux, rd_valid     read result, 2 cycles after rd_en
//   state, done, trig_addr, trig_missed  status
module adrv9001_axis_capture
  import adrv9001_capture_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int AUX_WIDTH    = 16,
  parameter int ADDR_WIDTH   = 10,
  parameter int PERIOD_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic [AUX_WIDTH-1:0]    aux,
  input  logic                    arm,
  input  logic                    abort,
  input  logic [1:0]              trig_mode,
  input  logic                    trig_ext,
  input  logic [ADDR_WIDTH-1:0]   pretrig_cnt,
  input  logic [PERIOD_WIDTH-1:0] period_cnt,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  input  logic                    rd_en,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic [AUX_WIDTH-1:0]    rd_aux,
  output logic                    rd_valid,
  output logic [2:0]              state,
  output logic                    done,
  output logic [ADDR_WIDTH-1:0]   trig_addr,
  output logic                    trig_missed
);

  localparam int RAM_W = DATA_WIDTH + AUX_WIDTH;
  localparam logic [ADDR_WIDTH-1:0]   A_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0]   A_LAST = ADDR_WIDTH'((2**ADDR_WIDTH) - 1);
  localparam logic [PERIOD_WIDTH-1:0] P_ONE  = PERIOD_WIDTH'(1);

  state_t st_q, st_d;

  logic                    beat, wr_en, arm_go, trig_hit, trig_take;
  logic [ADDR_WIDTH-1:0]   wr_ptr, pre_q, pre_cnt, post_cnt, raddr;
  logic [PERIOD_WIDTH-1:0] per_cnt;
  logic                    per_pulse, per_pend;
  logic                    ext_q, ext_edge, ext_pend;
  logic [RAM_W-1:0]        ram_q;
  logic [2:1]              vld_pipe;

  assign beat      = s_axis_tvalid & s_axis_tready;
  assign wr_en     = beat & (st_q inside {ST_PREFILL, ST_WAIT_TRIG, ST_POST});
  assign arm_go    = arm & ~abort & (st_q inside {ST_IDLE, ST_DONE});
  assign per_pulse = (per_cnt >= period_cnt);
  assign ext_edge  = trig_ext & ~ext_q;

  // Edge/pulse sources are held in *_pend until a beat consumes them, so a
  // trigger that fires between beats lands on the next beat.
  always_comb begin
    trig_hit = 1'b0;
    case (trig_mode)
      TRIG_IMMEDIATE: trig_hit = 1'b1;
      TRIG_TLAST:     trig_hit = s_axis_tlast;
      TRIG_EXT:       trig_hit = ext_pend | ext_edge;
      TRIG_PERIODIC:  trig_hit = per_pend | per_pulse;
      default:        trig_hit = 1'b0;
    endcase
  end

  assign trig_take = (st_q == ST_WAIT_TRIG) & beat & trig_hit;

  always_comb begin
    st_d = st_q;
    if (abort) st_d = ST_IDLE;
    else begin
      case (st_q)
        ST_IDLE, ST_DONE:
          if (arm) st_d = (pretrig_cnt == '0) ? ST_WAIT_TRIG : ST_PREFILL;
        ST_PREFILL:
          if (beat && pre_cnt == pre_q - A_ONE) st_d = ST_WAIT_TRIG;
        ST_WAIT_TRIG:
          // post = DEPTH-1-pre is zero only when pre is all-ones
          if (trig_take) st_d = (pre_q == A_LAST) ? ST_DONE : ST_POST;
        ST_POST:
          if (beat && post_cnt == A_ONE) st_d = ST_DONE;
        default: st_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q        <= ST_IDLE;
      wr_ptr      <= '0;
      pre_q       <= '0;
      pre_cnt     <= '0;
      post_cnt    <= '0;
      trig_addr   <= '0;
      trig_missed <= 1'b0;
      per_cnt     <= '0;
      per_pend    <= 1'b0;
      ext_q       <= 1'b0;
      ext_pend    <= 1'b0;
    end else begin
      st_q    <= st_d;
      ext_q   <= trig_ext;
      per_cnt <= per_pulse ? '0 : per_cnt + P_ONE;
      if (wr_en) wr_ptr <= wr_ptr + A_ONE;
      if (arm_go) begin
        // pretrig_cnt is ADDR_WIDTH wide, so it can never exceed DEPTH-1.
        // Stale pending triggers are dropped so a new capture starts clean.
        pre_q       <= pretrig_cnt;
        pre_cnt     <= '0;
        trig_missed <= 1'b0;
        ext_pend    <= 1'b0;
        per_pend    <= 1'b0;
      end else begin
        if (beat)          ext_pend <= 1'b0;
        else if (ext_edge) ext_pend <= 1'b1;
        if (beat)           per_pend <= 1'b0;
        else if (per_pulse) per_pend <= 1'b1;
        if (st_q == ST_PREFILL && beat) begin
          pre_cnt <= pre_cnt + A_ONE;
          if (trig_hit) trig_missed <= 1'b1;
        end
        if (trig_take) begin
          trig_addr <= wr_ptr;
          post_cnt  <= A_LAST - pre_q;
        end else if (st_q == ST_POST && beat) begin
          post_cnt <= post_cnt - A_ONE;
        end
      end
    end
  end

  // Logical index -> physical address, rebased on the oldest captured beat.
  assign raddr = trig_addr - pre_q + rd_addr;

  adrv9001_capture_ram #(
    .WIDTH      (RAM_W),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata ({s_axis_tdata, aux}),
    .re    (rd_en),
    .raddr (raddr),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      rd_data  <= '0;
      rd_aux   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[1], rd_en};
      if (vld_pipe[1]) {rd_data, rd_aux} <= ram_q;
    end
  end

  assign rd_valid = vld_pipe[2];
  assign state    = st_q;
  assign done     = (st_q == ST_DONE);

endmodule

// File: tb/tb_adrv9001_axis_capture.sv
// Directed bench for adrv9001_axis_capture with a 16-deep buffer.
module tb_adrv9001_axis_capture;

  localparam int DW = 32;
  localparam int XW = 16;
  localparam int AW = 4;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic [XW-1:0] aux = '0;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic [1:0]    trig_mode = '0;
  logic          trig_ext = 1'b0;
  logic [AW-1:0] pretrig_cnt = '0;
  logic [PW-1:0] period_cnt = '0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] rd_data;
  logic [XW-1:0] rd_aux;
  logic          rd_valid;
  logic [2:0]    state;
  logic          done;
  logic [AW-1:0] trig_addr;
  logic          trig_missed;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  adrv9001_axis_capture #(
    .DATA_WIDTH(DW), .AUX_WIDTH(XW), .ADDR_WIDTH(AW), .PERIOD_WIDTH(PW)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .aux(aux), .arm(arm), .abort(abort), .trig_mode(trig_mode),
    .trig_ext(trig_ext), .pretrig_cnt(pretrig_cnt), .period_cnt(period_cnt),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data), .rd_aux(rd_aux),
    .rd_valid(rd_valid), .state(state), .done(done),
    .trig_addr(trig_addr), .trig_missed(trig_missed)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One beat; tvalid drops after the edge so back-to-back calls stay continuous.
  task automatic beat(input logic [31:0] d, input logic last);
    s_axis_tvalid = 1'b1;
    s_axis_tready = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    aux           = d[15:0] ^ 16'hA5A5;
    step();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_axis_tvalid = 1'b0; s_axis_tready = 1'b0; s_axis_tlast = 1'b0;
    arm = 1'b0; abort = 1'b0; trig_ext = 1'b0; rd_en = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic do_arm(input logic [1:0] m, input logic [AW-1:0] p);
    trig_mode   = m;
    pretrig_cnt = p;
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [AW-1:0] a, input logic [31:0] exp);
    logic [15:0] exp_aux;
    exp_aux = exp[15:0] ^ 16'hA5A5;
    rd_addr = a;
    rd_en   = 1'b1;
    step();
    rd_en = 1'b0;
    check({tag, " valid@1"}, rd_valid, 0);
    step();
    check({tag, " valid@2"}, rd_valid, 1);
    check({tag, " data"}, rd_data, exp);
    check({tag, " aux"}, rd_aux, exp_aux);
  endtask

  initial begin
    // ---------------- reset state ----------------
    do_reset();
    check("rst state", state, 0);
    check("rst done", done, 0);
    check("rst trig_addr", trig_addr, 0);
    check("rst trig_missed", trig_missed, 0);
    check("rst rd_valid", rd_valid, 0);
    check("rst rd_data", rd_data, 0);
    check("rst rd_aux", rd_aux, 0);

    // ---------------- T1: immediate, pre=0 ----------------
    do_arm(2'd0, 4'd0);
    check("t1 wait", state, 2);
    for (int n = 0; n <= 20; n++) begin
      beat(n, 1'b0);
      if (n == 0)  check("t1 trig_addr", trig_addr, 0);
      if (n == 14) check("t1 post", state, 3);
      if (n == 15) begin check("t1 done st", state, 4); check("t1 done", done, 1); end
    end
    check("t1 still done", state, 4);
    for (int i = 0; i < 18; i++) begin
      rd_en   = (i < 16);
      rd_addr = AW'(i);
      step();
      if (i == 0) check("t1 lat", rd_valid, 0);
      else if (i <= 16) begin
        check($sformatf("t1 rv%0d", i - 1), rd_valid, 1);
        check($sformatf("t1 rd%0d", i - 1), rd_data, i - 1);
      end else check("t1 rv end", rd_valid, 0);
    end
    rd_en = 1'b0;

    // ---------------- T2: tlast, pre=4, trigger on beat 10 ----------------
    do_reset();
    do_arm(2'd1, 4'd4);
    check("t2 prefill", state, 1);
    for (int n = 0; n <= 21; n++) begin
      beat(n, n == 10);
      if (n == 3)  check("t2 wait", state, 2);
      if (n == 9)  check("t2 still wait", state, 2);
      if (n == 10) check("t2 post", state, 3);
    end
    check("t2 done", state, 4);
    check("t2 trig_addr", trig_addr, 10);
    check("t2 missed", trig_missed, 0);
    read_chk("t2 rd4", 4'd4, 10);
    read_chk("t2 rd0", 4'd0, 6);
    read_chk("t2 rd15", 4'd15, 21);

    // ---------------- T3: tlast during PREFILL is missed ----------------
    do_reset();
    do_arm(2'd1, 4'd4);
    for (int n = 0; n <= 23; n++) begin
      beat(n, (n == 2) || (n == 12));
      if (n == 2) begin check("t3 missed", trig_missed, 1); check("t3 pf", state, 1); end
      if (n == 3) check("t3 wait", state, 2);
    end
    check("t3 done", state, 4);
    check("t3 trig_addr", trig_addr, 12);
    read_chk("t3 rd4", 4'd4, 12);
    read_chk("t3 rd0", 4'd0, 8);
    read_chk("t3 rd15", 4'd15, 23);

    // ---------------- T4: ext edge, pre=15 ----------------
    do_reset();
    do_arm(2'd2, 4'd15);
    check("t4 prefill", state, 1);
    for (int n = 0; n <= 19; n++) begin
      beat(n, 1'b0);
      if (n == 14) check("t4 wait", state, 2);
    end
    check("t4 no trig", state, 2);
    trig_ext = 1'b1;
    step();
    check("t4 edge no beat", state, 2);
    beat(20, 1'b0);
    check("t4 done", state, 4);
    check("t4 done flag", done, 1);
    check("t4 trig_addr", trig_addr, 4);
    trig_ext = 1'b0;
    read_chk("t4 rd15", 4'd15, 20);
    read_chk("t4 rd0", 4'd0, 5);
    read_chk("t4 rd14", 4'd14, 19);

    // ---------------- T5: periodic, period_cnt=7, gapped beats ----------------
    do_reset();
    trig_mode  = 2'd3;
    period_cnt = '0;
    step();                 // counter forced to 0
    period_cnt = 16'd7;
    do_arm(2'd3, 4'd0);     // counter = 1 after this edge
    check("t5 wait", state, 2);
    for (int n = 0; n <= 18; n++) begin
      step();               // gap cycle; pulse falls in the gap before beat 3
      beat(32'h100 + n, 1'b0);
      if (n == 2) check("t5 pre-pulse", state, 2);
      if (n == 3) begin check("t5 post", state, 3); check("t5 trig_addr", trig_addr, 3); end
    end
    check("t5 done", state, 4);
    read_chk("t5 rd0", 4'd0, 32'h103);
    read_chk("t5 rd12", 4'd12, 32'h10F);
    read_chk("t5 rd13 wrap", 4'd13, 32'h110);
    read_chk("t5 rd15", 4'd15, 32'h112);

    // ---------------- T6: abort, arm+abort, async reset ----------------
    do_reset();
    do_arm(2'd0, 4'd0);
    for (int n = 0; n <= 4; n++) beat(32'h200 + n, 1'b0);
    check("t6 post", state, 3);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t6 abort idle", state, 0);
    for (int n = 0; n < 3; n++) beat(32'h2F0 + n, 1'b0);
    check("t6 idle beats", state, 0);
    check("t6 trig kept", trig_addr, 0);
    read_chk("t6 rd1", 4'd1, 32'h201);
    read_chk("t6 rd4", 4'd4, 32'h204);
    trig_mode = 2'd0; pretrig_cnt = '0;
    arm = 1'b1; abort = 1'b1;
    step();
    arm = 1'b0; abort = 1'b0;
    check("t6 arm+abort", state, 0);
    do_arm(2'd0, 4'd0);
    check("t6 rearm", state, 2);
    beat(32'h300, 1'b0);
    check("t6 ptr after idle", trig_addr, 5);
    check("t6 post2", state, 3);
    abort = 1'b1;
    step();
    abort = 1'b0;
    do_arm(2'd1, 4'd0);
    check("t6 wait", state, 2);
    rst = 1'b1;
    #2;
    check("t6 async state", state, 0);
    check("t6 async done", done, 0);
    step();
    rst = 1'b0;
    step();
    check("t6 after rst", state, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adrv9001_axis_capture.md
Name: adrv9001_axis_capture

Overview:
Parametrised, self-contained successor to the fixed-probe AXIS debug tap. It records an AXI-Stream data lane plus an auxiliary word (DGPIO monitor) into a circular on-chip buffer, with programmable pre-trigger depth and four trigger modes. Captured data is read back through a simple synchronous read port for PS/register access. It sits in the adrv9001 clock domain beside the Rx/Tx AXIS paths. All inputs must already be synchronous to clk.

Parameters:
DATA_WIDTH, 32, AXIS tdata width captured per beat
AUX_WIDTH, 16, auxiliary word width stored alongside each beat
ADDR_WIDTH, 10, buffer depth DEPTH = 2**ADDR_WIDTH beats
PERIOD_WIDTH, 16, width of the periodic trigger counter

Ports:
clk  in  1  capture/read clock
rst  in  1  asynchronous, active-high reset
s_axis_tdata  in  DATA_WIDTH  monitored stream data
s_axis_tvalid  in  1  monitored tvalid
s_axis_tready  in  1  monitored tready; beat = tvalid & tready
s_axis_tlast  in  1  monitored tlast
aux  in  AUX_WIDTH  auxiliary word sampled with each beat
arm  in  1  pulse; starts a capture from IDLE or DONE
abort  in  1  pulse; returns to IDLE from any state
trig_mode  in  2  0 immediate, 1 tlast beat, 2 trig_ext rising edge, 3 periodic
trig_ext  in  1  external trigger level
pretrig_cnt  in  ADDR_WIDTH  beats kept before the trigger; sampled on arm
period_cnt  in  PERIOD_WIDTH  periodic trigger interval in clk cycles, minus 1
rd_addr  in  ADDR_WIDTH  logical read index (0 = oldest sample)
rd_en  in  1  read strobe
rd_data  out  DATA_WIDTH  read data
rd_aux  out  AUX_WIDTH  read aux word
rd_valid  out  1  read data valid
state  out  3  current FSM state
done  out  1  high in DONE
trig_addr  out  ADDR_WIDTH  physical address of the trigger beat
trig_missed  out  1  sticky: trigger condition seen during PREFILL

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, write pointer 0, periodic counter 0, trig_ext history 0.
- FSM states: IDLE=0, PREFILL=1, WAIT_TRIG=2, POST=3, DONE=4.
- IDLE or DONE, arm=1: latch pre = min(pretrig_cnt, DEPTH-1) and clear trig_missed and the pre-counter. Go to PREFILL, or directly to WAIT_TRIG when pre=0. Arm in any other state is ignored.
- The write pointer increments modulo DEPTH on every beat in PREFILL, WAIT_TRIG and POST. Each beat writes {tdata, aux} at the pointer. No writes occur in IDLE or DONE.
- PREFILL: count beats. After the pre-th beat, move to WAIT_TRIG on the next cycle. A trigger condition on a PREFILL beat is not acted on and sets trig_missed.
- WAIT_TRIG: evaluate the trigger only on a beat. Mode 0: any beat. Mode 1: beat with tlast=1. Mode 2: a trig_ext 0->1 edge, latched until the next beat. Mode 3: a periodic pulse, latched until the next beat. The trigger beat is written, trig_addr takes its address, post-counter = DEPTH-1-pre. If post = 0, go to DONE; otherwise go to POST.
- POST: decrement the post-counter per beat. The beat that brings it to 0 is written, and the FSM is in DONE on the following cycle.
- Periodic counter: free-runs every clk cycle. When counter >= period_cnt, it resets to 0 and emits a 1-cycle pulse. period_cnt=0 produces a pulse every cycle.
- Every capture holds exactly DEPTH consecutive beats: oldest at physical (trig_addr - pre) mod DEPTH, trigger at logical index pre.
- Read port: physical = (trig_addr - pre + rd_addr) mod DEPTH. Latency is 2 cycles (registered RAM plus output register). rd_valid asserts 2 cycles after rd_en. Reads are accepted in every state; contents are only guaranteed in DONE. Back-to-back reads are supported at 1 per cycle.
- abort: the FSM returns to IDLE next cycle. Buffer contents, trig_addr and trig_missed are kept. Same-cycle arm and abort: abort wins.
- Async reset mid-capture: the FSM returns to IDLE immediately. RAM contents are undefined.

Decomposition:
- Package adrv9001_capture_pkg: FSM state encodings, trig_mode constants (TRIG_IMMEDIATE, TRIG_TLAST, TRIG_EXT, TRIG_PERIODIC).
- Sub-module adrv9001_capture_ram: simple dual-port RAM, width DATA_WIDTH+AUX_WIDTH, depth 2**ADDR_WIDTH, one write port, registered read port. The top adds the output register.

Test Plan:
(Bench uses ADDR_WIDTH=4, DEPTH=16.)
- Mode 0, pre=0, beats carry tdata=0..20, arm -> DONE after 16 beats, trig_addr=0, rd_addr 0..15 returns 0..15, rd_valid 2 cycles after rd_en.
- Mode 1, pre=4, tdata=incrementing from 0, tlast on beat 10 -> trig_addr=10, rd_addr 4 = 10, rd_addr 0 = 6, rd_addr 15 = 21.
- Mode 1, pre=4, tlast on beat 2 (during PREFILL) and again on beat 12 -> trig_missed=1, trigger taken at beat 12, rd_addr 4 = 12.
- Mode 2, pre=15, continuous beats, trig_ext rising edge between beats -> trigger on the next beat, DONE the cycle after that beat (post=0), 15 older samples readable.
- Mode 3, period_cnt=7, beats gated by tvalid toggling -> trigger on the first beat after the pulse, trig_addr matches that beat; wrap-around read across address 15->0 is correct.
- abort during POST -> IDLE next cycle, no further writes. Arm with abort in the same cycle from IDLE -> stays IDLE. Async rst during WAIT_TRIG -> state=0 and done=0 immediately.
